// File: rtl/integral_row_feeder.sv
// Purpose: turns a raster pixel stream into per-column integral / squared-integral / row-prefix words.
// Latency: one word 1 cycle after each accepted pixel; START 1 cycle after a row's last word, FRAME_DONE 1 after last START.
// Backpressure: PIX_READY drops for one cycle at each row end, in FRAME_END and IDLE, and in any FRAME_START cycle.
module integral_row_feeder #(
    parameter int WIN_W = 20,
    parameter int ROWS  = 20,
    parameter int PIX_W = 8,
    parameter int ACC_W = 32
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               FRAME_START,
    input  logic               PIX_VALID,
    input  logic [PIX_W-1:0]   PIX_IN,
    output logic               PIX_READY,
    output logic [8:0]         ADDR,
    output logic [3*ACC_W-1:0] XYZ_OUT,
    output logic               WORD_VALID,
    output logic               START,
    output logic               FRAME_DONE
);

    localparam int COL_W = (WIN_W > 1) ? $clog2(WIN_W) : 1;
    localparam int ROW_W = $clog2(ROWS + 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIN_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACCUM     = 2'd1,
        ROW_END   = 2'd2,
        FRAME_END = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic [ACC_W-1:0] row_sum_q;
    logic [ACC_W-1:0] row_sq_q;
    logic [ACC_W-1:0] colacc [WIN_W];
    logic [ACC_W-1:0] sqacc  [WIN_W];

    logic               xfer;
    logic               start_nxt;
    logic               done_nxt;
    logic [2*PIX_W-1:0] pix_sq_raw;
    logic [ACC_W-1:0]   pix_ext;
    logic [ACC_W-1:0]   pix_sq;
    logic [ACC_W-1:0]   rs_nxt;
    logic [ACC_W-1:0]   rq_nxt;
    logic [ACC_W-1:0]   x_sum;
    logic [ACC_W-1:0]   y_sum;

    assign xfer = PIX_VALID & PIX_READY;

    // Per-pixel arithmetic: running row prefix sums plus the column accumulators above.
    always_comb begin
        pix_sq_raw = {{PIX_W{1'b0}}, PIX_IN} * {{PIX_W{1'b0}}, PIX_IN};
        pix_ext    = ACC_W'(PIX_IN);
        pix_sq     = ACC_W'(pix_sq_raw);
        rs_nxt     = row_sum_q + pix_ext;
        rq_nxt     = row_sq_q + pix_sq;
        x_sum      = colacc[col_q] + rs_nxt;
        y_sum      = sqacc[col_q] + rq_nxt;
    end

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; FRAME_START from any state restarts at row 0.
    always_comb begin
        state_d = state_q;
        if (FRAME_START) begin
            state_d = ACCUM;
        end else begin
            case (state_q)
                IDLE:      state_d = IDLE;
                ACCUM:     if (xfer && (col_q == COL_LAST)) state_d = ROW_END;
                ROW_END:   state_d = (row_q == ROW_LAST) ? FRAME_END : ACCUM;
                FRAME_END: state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end
    end

    // Output decode; a FRAME_START cycle never accepts a pixel and cancels a pending START.
    always_comb begin
        PIX_READY = (state_q == ACCUM) && !FRAME_START;
        start_nxt = (state_q == ROW_END) && !FRAME_START;
        done_nxt  = (state_q == FRAME_END) && !FRAME_START;
    end

    // Counters, row prefix sums and column accumulators.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            col_q     <= '0;
            row_q     <= '0;
            row_sum_q <= '0;
            row_sq_q  <= '0;
            for (int i = 0; i < WIN_W; i++) begin
                colacc[i] <= '0;
                sqacc[i]  <= '0;
            end
        end else if (FRAME_START) begin
            col_q     <= '0;
            row_q     <= '0;
            row_sum_q <= '0;
            row_sq_q  <= '0;
            for (int i = 0; i < WIN_W; i++) begin
                colacc[i] <= '0;
                sqacc[i]  <= '0;
            end
        end else if (xfer) begin
            colacc[col_q] <= x_sum;
            sqacc[col_q]  <= y_sum;
            row_sum_q     <= rs_nxt;
            row_sq_q      <= rq_nxt;
            col_q         <= (col_q == COL_LAST) ? '0 : col_q + COL_W'(1);
        end else if (state_q == ROW_END) begin
            row_sum_q <= '0;
            row_sq_q  <= '0;
            col_q     <= '0;
            row_q     <= row_q + ROW_W'(1);
        end
    end

    // Registered word and pulse outputs; ADDR/XYZ_OUT hold between words.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ADDR       <= '0;
            XYZ_OUT    <= '0;
            WORD_VALID <= 1'b0;
            START      <= 1'b0;
            FRAME_DONE <= 1'b0;
        end else begin
            WORD_VALID <= xfer;
            START      <= start_nxt;
            FRAME_DONE <= done_nxt;
            if (xfer) begin
                ADDR    <= 9'(col_q);
                XYZ_OUT <= {x_sum, y_sum, rs_nxt};
            end
        end
    end

endmodule
